// File: rtl/alu_ser_pkg.sv
// Shared types and constants for the ALU result serializer.
// The checksum feature itself is selected by ALU_SER_CHKSUM_EN in alu_result_serializer.
package alu_ser_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CHK  = 2'd2,
    DONE = 2'd3
  } ser_state_t;

  localparam logic [7:0] STATUS_TAG = 8'hA0;

  // Number of data bytes carried by one result word.
  function automatic int nbytes(input int res_w);
    return res_w / 8;
  endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// Small synchronous FIFO holding {carry, result} words for the serializer.
// A push while full is only taken when a pop happens on the same edge.
module alu_res_fifo
  import alu_ser_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // The extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_result_serializer.sv
// Queues arithmetic results and emits each one as a byte frame: status, data MSB first,
// then an XOR checksum byte when ALU_SER_CHKSUM_EN is defined.
module alu_result_serializer
  import alu_ser_pkg::*;
#(
  parameter int RES_W      = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [RES_W-1:0] IN_DATA,
  input  logic             IN_CARRY,
  input  logic             IN_VALID,
  output logic [7:0]       TX_DATA,
  output logic             TX_VALID,
  input  logic             TX_READY,
  output logic             BUSY,
  output logic             OVERFLOW,
  input  logic             OVF_CLR
);

  localparam int                NB       = nbytes(RES_W);
  localparam int                CNT_W    = $clog2(NB + 2);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NB);

  logic             fifo_full;
  logic             fifo_empty;
  logic [RES_W:0]   fifo_rdata;
  logic             pop;
  logic             drop;
  logic             hs;

  ser_state_t       state_q, state_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic [RES_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             overflow_q;
`ifdef ALU_SER_CHKSUM_EN
  logic [7:0]       chk_q, chk_d;
`endif

  alu_res_fifo #(
    .WIDTH (RES_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (IN_VALID),
    .pop   (pop),
    .wdata ({IN_CARRY, IN_DATA}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign hs   = tx_valid_q && TX_READY;
  assign drop = IN_VALID && fifo_full && !pop;

  // NOTE: every signal written here gets its hold value first, so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    pop        = 1'b0;
`ifdef ALU_SER_CHKSUM_EN
    chk_d      = chk_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_d    = fifo_rdata[RES_W-1:0];
          tx_data_d  = STATUS_TAG | {7'd0, fifo_rdata[RES_W]};
          tx_valid_d = 1'b1;
          cnt_d      = '0;
          state_d    = SEND;
`ifdef ALU_SER_CHKSUM_EN
          chk_d      = STATUS_TAG | {7'd0, fifo_rdata[RES_W]};
`endif
        end
      end
      SEND: begin
        if (hs) begin
          if (cnt_q == LAST_CNT) begin
`ifdef ALU_SER_CHKSUM_EN
            tx_data_d  = chk_q;
            cnt_d      = cnt_q + 1'b1;
            state_d    = CHK;
`else
            tx_valid_d = 1'b0;
            state_d    = DONE;
`endif
          end else begin
            // Top byte of the shift register is the next data byte on the wire.
            tx_data_d = shift_q[RES_W-1 -: 8];
            shift_d   = shift_q << 8;
            cnt_d     = cnt_q + 1'b1;
`ifdef ALU_SER_CHKSUM_EN
            chk_d     = chk_q ^ shift_q[RES_W-1 -: 8];
`endif
          end
        end
      end
      CHK: begin
        if (hs) begin
          tx_valid_d = 1'b0;
          state_d    = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      shift_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef ALU_SER_CHKSUM_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) chk_q <= '0;
    else      chk_q <= chk_d;
  end
`endif

  // A drop on the same edge as a clear wins, so no lost result goes unreported.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)         overflow_q <= 1'b0;
    else if (drop)    overflow_q <= 1'b1;
    else if (OVF_CLR) overflow_q <= 1'b0;
  end

  assign TX_DATA  = tx_data_q;
  assign TX_VALID = tx_valid_q;
  assign OVERFLOW = overflow_q;
  assign BUSY     = !fifo_empty || (state_q != IDLE);

endmodule
